// File: rtl/lookup_table_loader.sv
// rtl/lookup_table_loader.sv - block write/fill/dump engine driving a look-up table update port
module lookup_table_loader #(
  parameter int DEPTH      = 1024,
  parameter int DATA_BITS  = 32,
  localparam int ADDR_BITS = $clog2(DEPTH),
  localparam int LEN_BITS  = ADDR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [ADDR_BITS:0]   cmd_len,
  input  logic [DATA_BITS-1:0] cmd_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [ADDR_BITS-1:0] tbl_addr,
  output logic [DATA_BITS-1:0] tbl_din,
  output logic                 tbl_we,
  input  logic [DATA_BITS-1:0] tbl_dout,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0]  LEN_ZERO = '0;
  localparam logic [LEN_BITS-1:0]  LEN_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FILL,
    READ,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Walking address and count of table accesses still to issue.
  logic [ADDR_BITS-1:0] addr;
  logic [LEN_BITS-1:0]  remaining;
  // Words still to be handed out on the m stream during READ.
  logic [LEN_BITS-1:0]  pop_left;
  logic [DATA_BITS-1:0] fill_data;
  // A read was issued last cycle; tbl_dout holds its word this cycle.
  logic                 rd_pending;

  // Two-entry output FIFO for READ.
  logic [DATA_BITS-1:0] fifo_mem [2];
  logic                 fifo_wr_ptr;
  logic                 fifo_rd_ptr;
  logic [1:0]           fifo_count;

  // Per-cycle control decided by the FSM.
  logic                 accept;
  logic                 access;
  logic                 access_we;
  logic [ADDR_BITS-1:0] access_addr;
  logic [DATA_BITS-1:0] access_din;
  logic                 pop;
  logic [2:0]           occ_next;

  // Next state, handshakes and the table access to register this cycle.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    access      = 1'b0;
    access_we   = 1'b0;
    access_addr = addr;
    access_din  = fill_data;
    cmd_ready   = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == FINISH);
    s_ready     = (state == WRITE);
    m_valid     = (state == READ) && (fifo_count != 2'd0);
    m_data      = m_valid ? fifo_mem[fifo_rd_ptr] : '0;
    pop         = m_valid && m_ready;
    // Occupancy the FIFO would have next cycle without a new issue; counting
    // this cycle's pop keeps a word flowing every cycle under full m_ready.
    occ_next    = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == LEN_ZERO || cmd_op == OP_RSVD) begin
            state_next = FINISH;
          end else begin
            case (cmd_op)
              OP_WRITE: state_next = WRITE;
              OP_FILL: begin
                // First fill word is registered at accept so writes land in n+1..n+len.
                state_next  = FILL;
                access      = 1'b1;
                access_we   = 1'b1;
                access_addr = cmd_addr;
                access_din  = cmd_data;
              end
              default: begin
                // First read is issued at accept so data is on m in n+2.
                state_next  = READ;
                access      = 1'b1;
                access_addr = cmd_addr;
              end
            endcase
          end
        end
      end
      WRITE: begin
        if (s_valid) begin
          access     = 1'b1;
          access_we  = 1'b1;
          access_din = s_data;
          if (remaining == LEN_ONE) state_next = FINISH;
        end
      end
      FILL: begin
        if (remaining == LEN_ZERO) begin
          state_next = FINISH;
        end else begin
          access    = 1'b1;
          access_we = 1'b1;
        end
      end
      READ: begin
        if (remaining != LEN_ZERO && occ_next < 3'd2) access = 1'b1;
        if (pop && pop_left == LEN_ONE) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command latch, address walk and registered table port.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      pop_left   <= '0;
      fill_data  <= '0;
      err        <= 1'b0;
      rd_pending <= 1'b0;
      tbl_addr   <= '0;
      tbl_din    <= '0;
      tbl_we     <= 1'b0;
    end else begin
      tbl_we     <= 1'b0;
      rd_pending <= 1'b0;
      if (accept) begin
        err       <= (cmd_op == OP_RSVD);
        fill_data <= cmd_data;
        pop_left  <= cmd_len;
        addr      <= cmd_addr;
        remaining <= cmd_len;
      end
      if (access) begin
        tbl_addr   <= access_addr;
        tbl_we     <= access_we;
        rd_pending <= !access_we;
        if (access_we) tbl_din <= access_din;
        addr      <= access_addr + ADDR_ONE;
        remaining <= (accept ? cmd_len : remaining) - LEN_ONE;
      end
      if (pop) pop_left <= pop_left - LEN_ONE;
    end
  end

  // Output FIFO pointers and occupancy; reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (rd_pending) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)        fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, rd_pending} - {1'b0, pop};
    end
  end

  // Output FIFO storage; captures the table word the cycle after its read issue.
  always_ff @(posedge clk) begin
    if (rd_pending) fifo_mem[fifo_wr_ptr] <= tbl_dout;
  end

endmodule

// File: doc/lookup_table_loader.md
# lookup_table_loader

Sequential update/dump engine for the table's narrow (update) port. Accepts one command at a time, then writes a block of table words from an input stream, fills a block with a constant, or reads a block back out onto an output stream with backpressure. It sits between the control path and the writeable look-up table, owning that table's update address, data, write-enable and read-data signals. The wide lookup port is untouched.

## Interface
Parameters:
- DEPTH, 1024: table depth in words. Power of two, ≥ 4.
- DATA_BITS, 32: table word width.
- ADDR_BITS, clogb2(DEPTH): derived localparam for the word address width.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  0=WRITE (from stream), 1=FILL, 2=READ (dump), 3=reserved.
- cmd_addr  in  ADDR_BITS  start word address.
- cmd_len  in  ADDR_BITS+1  word count, 0..DEPTH.
- cmd_data  in  DATA_BITS  fill value (FILL only).
- s_valid / s_ready  in / out  1  write-data stream handshake.
- s_data  in  DATA_BITS  write word.
- m_valid / m_ready  out / in  1  read-data stream handshake.
- m_data  out  DATA_BITS  read word.
- tbl_addr  out  ADDR_BITS  table update-port address (registered).
- tbl_din  out  DATA_BITS  table write data (registered).
- tbl_we  out  1  table write enable (registered).
- tbl_dout  in  DATA_BITS  table read data; valid the cycle after tbl_addr was presented.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky until next accepted command; set by op 3.

## Operation
- FSM states: IDLE, WRITE, FILL, READ, FINISH.
- IDLE: cmd_ready=1. On accept, latch addr and len, clear err, go to the op state. len=0 goes straight to FINISH with no table access. Op 3 goes to FINISH, sets err, and makes no table access.
- WRITE: s_ready=1. Each s handshake registers tbl_we=1, tbl_addr=addr, tbl_din=s_data, then increments addr and decrements the remaining count. Gaps in s_valid produce tbl_we=0 cycles. After the last word, go to FINISH.
- FILL: one write per cycle with tbl_din=cmd_data, for len consecutive cycles, then FINISH.
- READ: issue a read (tbl_addr=addr, tbl_we=0) only when output FIFO occupancy plus in-flight reads is < 2. Capture tbl_dout into a 2-entry output FIFO the cycle after issue. m_valid = FIFO non-empty; m_data = FIFO head. Go to FINISH once all len words have been popped by m handshakes.
- FINISH: done=1 for one cycle, then IDLE.
- Address increments modulo DEPTH: DEPTH-1 wraps to 0.
- busy=1 in every state except IDLE.
- s_ready=0 outside WRITE. m_valid=0 outside READ.
- rst: state→IDLE and the FIFO is flushed. All outputs take reset values: cmd_ready=1 (the cycle after reset), all others 0. A partially completed command is abandoned with no done pulse. Writes already committed remain in the table.

## Timing
- Accept in cycle n → busy high from n+1. FILL writes occur in cycles n+1..n+len. done=1 in cycle n+len+1. cmd_ready=1 again in n+len+2.
- WRITE: s handshake in cycle k → tbl_we=1 in cycle k+1.
- READ, with m_ready held high: first m_valid in n+2, then one word per cycle. done is the cycle after the last pop.
- Throughput is one word per cycle in all ops with no backpressure. The FIFO never overflows under arbitrary m_ready.

## Test plan
- FILL addr=1022 len=4 data=0xA5A5A5A5 → tbl_we in 4 consecutive cycles at addrs 1022, 1023, 0, 1; done exactly once, 5 cycles after accept.
- WRITE addr=8 len=3 with words 0x11, 0x22, 0x33 and one idle cycle between each → writes to 8, 9, 10 each one cycle after its handshake; READ addr=8 len=3 → m_data 0x11, 0x22, 0x33.
- READ len=16 with m_ready toggling 1,0,0,1 pseudo-randomly → all 16 words in order, none dropped or duplicated, FIFO occupancy ≤ 2.
- len=0 and op=3 commands → no tbl_we and no m_valid; done pulses 1 cycle after accept; err=1 only for op 3, cleared by the next accept.
- rst asserted mid-WRITE after 2 of 5 words → next cycle busy=0, tbl_we=0, s_ready=0, no done; table holds only the 2 committed words.
- Back-to-back: a new command offered during done → not accepted until cmd_ready rises the following cycle.
